uart_rx_buffered: RTL and testbench

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

---
 rtl/rvsteel_uart_pkg.sv | 21 ++
 rtl/uart_rx_fifo.sv | 64 ++++++
 rtl/uart_rx_buffered.sv | 143 ++++++++++++++
 tb/tb_uart_rx_buffered.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvsteel_uart_pkg.sv
// Shared UART receiver definitions: state encoding and bit-timing derivation.
package rvsteel_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic int unsigned cycles_per_bit(input int unsigned clock_hz,
                                                 input int unsigned baud_rate);
    return clock_hz / baud_rate;
  endfunction

  function automatic int unsigned half_bit(input int unsigned bit_cycles);
    return bit_cycles / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fallthrough receive FIFO; a push into a full FIFO is dropped
// and flagged unless a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic             overrun
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  // Gated so the head reads zero whenever nothing is buffered.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      overrun <= push & full & ~do_pop;
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver (8N1, LSB first) feeding a first-word-fallthrough byte FIFO,
// with frame-error and overrun pulses.
module uart_rx_buffered
  import rvsteel_uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 27000000,
  parameter int unsigned UART_BAUD_RATE  = 9600,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQUENCY, UART_BAUD_RATE);
  localparam int unsigned HALF_BIT       = half_bit(CYCLES_PER_BIT);
  localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             rx_line;
  rx_state_t        state_q;
  rx_state_t        state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [2:0]       bit_q;
  logic [2:0]       bit_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             push;
  logic             stop_bad;
  logic             fifo_empty;
  logic             fifo_full;

  assign rx_line = sync_q2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= uart_rx;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_error <= stop_bad;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (!rx_line) begin
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        if (count_q == HALF_LAST) begin
          count_d = '0;
          state_d = rx_line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (count_q == BIT_LAST) begin
          count_d = '0;
          shift_d = {rx_line, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (count_q == BIT_LAST) begin
          count_d = '0;
          if (rx_line) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        count_d = '0;
        if (rx_line) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  uart_rx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (shift_q),
    .pop       (rx_ready),
    .head_data (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .overrun   (overrun)
  );

  assign rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: directed frames plus randomized traffic checked
// against a byte-queue model of the receive buffer.
module tb_uart_rx_buffered;

  localparam int unsigned CLOCK_FREQUENCY = 1000000;
  localparam int unsigned UART_BAUD_RATE  = 100000;
  localparam int unsigned FIFO_DEPTH      = 8;
  localparam int unsigned BIT_CYCLES      = CLOCK_FREQUENCY / UART_BAUD_RATE;
  // Start edge to rx_valid: two sync flops, one detect cycle, half a bit, nine bits.
  localparam int unsigned VALID_LATENCY   = 3 + BIT_CYCLES / 2 + 9 * BIT_CYCLES;

  logic       clock = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_error;
  logic       overrun;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cycle    = 0;
  int unsigned start_cycle = 0;
  int unsigned rise_cycle  = 0;
  int unsigned ferr_seen = 0;
  int unsigned ferr_exp  = 0;
  int unsigned ovr_seen  = 0;
  int unsigned ovr_exp   = 0;
  logic        prev_valid = 1'b0;
  bit          rand_ready = 1'b0;
  logic [7:0]  exp_q [$];

  always #5 clock = ~clock;

  uart_rx_buffered #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
    .UART_BAUD_RATE (UART_BAUD_RATE),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  always @(posedge clock) cycle <= cycle + 1;

  // Pulse widths are counted in high cycles, so a stretched pulse also shows up.
  always @(negedge clock) begin
    if (frame_error) ferr_seen++;
    if (overrun) ovr_seen++;
    if (rx_valid && !prev_valid) rise_cycle = cycle;
    prev_valid = rx_valid;
    if (!reset && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check_eq("pop_unexpected", 32'(rx_valid), 32'd0);
      else check_eq("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic drain(input int unsigned n);
    rx_ready = 1'b1;
    idle(n);
    rx_ready = 1'b0;
  endtask

  task automatic checkpoint(input string tag);
    check_eq({tag, "_valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check_eq({tag, "_head"}, 32'(rx_data), 32'(exp_q[0]));
    check_eq({tag, "_frame_error"}, ferr_seen, ferr_exp);
    check_eq({tag, "_overrun"}, ovr_seen, ovr_exp);
  endtask

  // Drives one 8N1 frame; the model is updated at the mid-stop-bit sample point.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int unsigned low_hold, input bit pop_at_push,
                            input int reset_bit);
    logic [9:0] bits;
    bit         was_reset;
    bits      = {stop_bit, data, 1'b0};
    was_reset = 1'b0;
    tick();
    uart_rx     = bits[0];
    start_cycle = cycle;
    for (int i = 0; i < 9; i++) begin
      if (i == reset_bit) begin
        idle(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        was_reset = 1'b1;
        idle(BIT_CYCLES - 5);
      end else begin
        idle(BIT_CYCLES);
      end
      uart_rx = bits[i+1];
    end
    idle(BIT_CYCLES - 3);
    if (pop_at_push) rx_ready = 1'b1;
    tick();
    if (pop_at_push) rx_ready = 1'b0;
    if (!was_reset) begin
      if (stop_bit) begin
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(data);
        else ovr_exp++;
      end else begin
        ferr_exp++;
      end
    end
    idle(2);
    if (!stop_bit && low_hold > BIT_CYCLES) idle(low_hold - BIT_CYCLES);
    uart_rx = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(2);
    check_eq("reset_valid", 32'(rx_valid), 32'd0);
    check_eq("reset_data", 32'(rx_data), 32'd0);
    check_eq("reset_frame_error", 32'(frame_error), 32'd0);
    check_eq("reset_overrun", 32'(overrun), 32'd0);

    // Single good frame, left unread.
    send_frame(8'h48, 1'b1, 0, 1'b0, -1);
    idle(2);
    check_eq("t1_latency", rise_cycle - start_cycle, VALID_LATENCY);
    checkpoint("t1");

    // Bad stop bit with a held break, then a clean frame.
    send_frame(8'h55, 1'b0, 30, 1'b0, -1);
    idle(5);
    checkpoint("t2");
    send_frame(8'h3C, 1'b1, 0, 1'b0, -1);
    idle(3);
    checkpoint("t3");
    drain(5);
    checkpoint("t3_drained");

    // Short low glitch on an idle line.
    uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    idle(20);
    checkpoint("t4");
    send_frame(8'h5A, 1'b1, 0, 1'b0, -1);
    idle(3);
    checkpoint("t4_next");
    drain(4);

    // Nine bytes into an eight-deep buffer with no consumer.
    for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b1, 0, 1'b0, -1);
    idle(3);
    checkpoint("t5_full");
    idle(20);
    checkpoint("t5_hold");
    drain(12);
    checkpoint("t5_drained");

    // Full buffer, consumer pops on the very cycle of the push.
    for (int b = 0; b < 8; b++) send_frame(8'(8'h11 + b), 1'b1, 0, 1'b0, -1);
    send_frame(8'h7E, 1'b1, 0, 1'b1, -1);
    idle(3);
    checkpoint("t6_full");
    drain(12);
    checkpoint("t6_drained");

    // Reset mid-frame abandons the frame and empties the buffer.
    send_frame(8'h20, 1'b1, 0, 1'b0, -1);
    send_frame(8'hF3, 1'b1, 0, 1'b0, 4);
    idle(5);
    check_eq("t7_data", 32'(rx_data), 32'd0);
    checkpoint("t7");
    send_frame(8'hA5, 1'b1, 0, 1'b0, -1);
    idle(3);
    checkpoint("t7_next");
    drain(4);

    // Randomized traffic with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      logic       good;
      logic [7:0] val;
      good = ($urandom_range(0, 5) != 0);
      val  = 8'($urandom);
      send_frame(val, good, $urandom_range(10, 25), 1'b0, -1);
      idle(4 + $urandom_range(0, 15));
    end
    rand_ready = 1'b0;
    drain(15);
    checkpoint("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
